doppler_search_ctrl: RTL and testbench

DOPPLER_SEARCH_CTRL -- requirements
Module: doppler_search_ctrl

---
 rtl/gps_ctrl_pkg.sv | 27 ++
 rtl/run_counter.sv | 36 +++
 rtl/doppler_search_ctrl.sv | 157 +++++++++++++++
 tb/tb_doppler_search_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gps_ctrl_pkg.sv
// Shared types for the GPS acquisition/tracking control blocks.
package gps_ctrl_pkg;

    // IF counts per 40 ms window and Doppler set-points share this width.
    localparam int FREQ_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_DWELL  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } search_state_t;

    // |meas - set| <= tol, evaluated in a 13-bit signed difference so that
    // no 12-bit wrap can make a far-off measurement look settled.
    function automatic logic freq_within(input logic [FREQ_W-1:0] meas,
                                         input logic [FREQ_W-1:0] set,
                                         input int                tol);
        logic signed [FREQ_W:0] diff;
        logic signed [FREQ_W:0] lim;
        diff = $signed({1'b0, meas}) - $signed({1'b0, set});
        lim  = (FREQ_W+1)'(tol);
        return (diff <= lim) && (diff >= -lim);
    endfunction

endpackage

// File: rtl/run_counter.sv
// Counts qualifying strobes; a non-hit strobe restarts the run. 'reached'
// fires combinationally on the strobe that completes a run of N hits.
module run_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hit,
    input  logic clear,
    output logic reached
);
    localparam int W = $clog2(N + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign reached = en && hit && (cnt_q == W'(N - 1));

    // Next count: clear dominates, otherwise advance or restart on each strobe.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (!hit)         cnt_d = '0;
            else if (!reached) cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/doppler_search_ctrl.sv
// Doppler bin search: steps the set-point FMIN..FMAX, waits for the IF loop
// to settle, dwells watching code lock, and holds the bin while locked.
module doppler_search_ctrl
    import gps_ctrl_pkg::*;
#(
    parameter int FMIN       = 1000,
    parameter int FMAX       = 1100,
    parameter int STEP       = 10,
    parameter int TOL        = 2,
    parameter int SETTLE_MAX = 16,
    parameter int DWELL      = 8,
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 3,
    parameter int MAX_SWEEPS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              meas_valid,
    input  logic [FREQ_W-1:0] iffreq,
    input  logic              codetrack,
    output logic [FREQ_W-1:0] dopset,
    output logic              doptrack,
    output logic              busy,
    output logic              locked,
    output logic              fail,
    output logic [1:0]        sweep
);

    search_state_t     state_q, state_d;
    logic [FREQ_W-1:0] dopset_q, dopset_d;
    logic [1:0]        sweep_q, sweep_d;
    logic              doptrack_q, busy_q, locked_q, fail_q;

    logic              settled, restart, next_bin;
    logic              settle_done, dwell_done, lock_done, loss_done;
    logic [FREQ_W:0]   bin_sum;
    logic [2:0]        sweep_inc;

    assign settled   = freq_within(iffreq, dopset_q, TOL);
    assign bin_sum   = {1'b0, dopset_q} + (FREQ_W+1)'(STEP);
    assign sweep_inc = {1'b0, sweep_q} + 3'd1;

    // Unsettled strobes in SETTLE (a settled one leaves the state anyway).
    run_counter #(.N(SETTLE_MAX)) u_settle (
        .clk(clk), .rst(rst), .clear(restart),
        .en(meas_valid && state_q == ST_SETTLE), .hit(!settled),
        .reached(settle_done));

    // Total strobes spent in DWELL.
    run_counter #(.N(DWELL)) u_dwell (
        .clk(clk), .rst(rst), .clear(restart),
        .en(meas_valid && state_q == ST_DWELL), .hit(1'b1),
        .reached(dwell_done));

    // Consecutive codetrack-high strobes in DWELL.
    run_counter #(.N(LOCK_CNT)) u_lock (
        .clk(clk), .rst(rst), .clear(restart),
        .en(meas_valid && state_q == ST_DWELL), .hit(codetrack),
        .reached(lock_done));

    // Consecutive codetrack-low strobes in LOCKED.
    run_counter #(.N(LOSS_CNT)) u_loss (
        .clk(clk), .rst(rst), .clear(restart),
        .en(meas_valid && state_q == ST_LOCKED), .hit(!codetrack),
        .reached(loss_done));

    // Next-state, set-point and sweep logic; restart clears all run counters.
    always_comb begin
        state_d  = state_q;
        dopset_d = dopset_q;
        sweep_d  = sweep_q;
        restart  = 1'b0;
        next_bin = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            restart = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAIL: begin
                    if (start) begin
                        state_d  = ST_SETTLE;
                        dopset_d = FREQ_W'(FMIN);
                        sweep_d  = '0;
                        restart  = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (meas_valid && settled) begin
                        state_d = ST_DWELL;
                        restart = 1'b1;
                    end else if (settle_done) begin
                        next_bin = 1'b1;
                    end
                end
                ST_DWELL: begin
                    // Lock completing on the last dwell strobe still wins.
                    if (lock_done) begin
                        state_d = ST_LOCKED;
                        restart = 1'b1;
                    end else if (dwell_done) begin
                        next_bin = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (loss_done) next_bin = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    restart = 1'b1;
                end
            endcase
            if (next_bin) begin
                restart = 1'b1;
                state_d = ST_SETTLE;
                if (bin_sum > (FREQ_W+1)'(FMAX)) begin
                    dopset_d = FREQ_W'(FMIN);
                    sweep_d  = sweep_inc[1:0];
                    if (sweep_inc >= 3'(MAX_SWEEPS)) state_d = ST_FAIL;
                end else begin
                    dopset_d = bin_sum[FREQ_W-1:0];
                end
            end
        end
    end

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dopset_q   <= FREQ_W'(FMIN);
            sweep_q    <= '0;
            doptrack_q <= 1'b0;
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dopset_q   <= dopset_d;
            sweep_q    <= sweep_d;
            doptrack_q <= (state_d == ST_LOCKED);
            locked_q   <= (state_d == ST_LOCKED);
            fail_q     <= (state_d == ST_FAIL);
            busy_q     <= (state_d == ST_SETTLE) || (state_d == ST_DWELL) ||
                          (state_d == ST_LOCKED);
        end
    end

    assign dopset   = dopset_q;
    assign sweep    = sweep_q;
    assign doptrack = doptrack_q;
    assign busy     = busy_q;
    assign locked   = locked_q;
    assign fail     = fail_q;

endmodule

// File: tb/tb_doppler_search_ctrl.sv
// Directed bench for doppler_search_ctrl with default parameters.
module tb_doppler_search_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, meas_valid, codetrack;
    logic [11:0] iffreq;
    logic [11:0] dopset;
    logic        doptrack, busy, locked, fail;
    logic [1:0]  sweep;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    doppler_search_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .meas_valid(meas_valid), .iffreq(iffreq), .codetrack(codetrack),
        .dopset(dopset), .doptrack(doptrack), .busy(busy), .locked(locked),
        .fail(fail), .sweep(sweep));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge; outputs are sampled there.
    task automatic strobe(input int f, input logic ct);
        meas_valid = 1'b1; iffreq = 12'(f); codetrack = ct;
        @(negedge clk);
        meas_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; @(negedge clk); abort = 1'b0;
    endtask

    // Settle on the bin, then dwell 8 strobes without lock.
    task automatic skip_bin(input int f);
        strobe(f, 1'b0);
        repeat (8) strobe(f, 1'b0);
    endtask

    // iffreq stuck at 0: every bin times out after 16 strobes; 3 sweeps -> FAIL.
    task automatic run_sweeps();
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 11; b++) begin
                repeat (16) strobe(0, 1'b0);
                chk("sweep_bin_dopset", dopset, (b < 10) ? 1000 + 10*(b+1) : 1000);
            end
            chk("sweep_count", sweep, s + 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; meas_valid = 1'b0;
        codetrack = 1'b0; iffreq = '0;
        repeat (2) @(negedge clk);
        chk("rst_dopset", dopset, 1000);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {doptrack, locked, fail}, 0);
        chk("rst_sweep", sweep, 0);
        rst = 1'b0;
        @(negedge clk);

        // Lock at 1000: settle on strobe 1, codetrack high strobes 2..5.
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_dopset", dopset, 1000);
        strobe(1000, 1'b0);
        repeat (3) strobe(1000, 1'b1);
        chk("lock3_not_locked", locked, 0);
        strobe(1000, 1'b1);
        chk("lock4_locked", locked, 1);
        chk("lock4_doptrack", doptrack, 1);
        chk("lock4_dopset", dopset, 1000);
        pulse_start();
        chk("start_ignored_locked", locked, 1);
        chk("start_ignored_dopset", dopset, 1000);

        // Loss of lock -> next bin.
        repeat (3) strobe(1000, 1'b0);
        chk("loss_dopset", dopset, 1010);
        chk("loss_doptrack", doptrack, 0);

        skip_bin(1010);
        chk("dwell_skip_dopset", dopset, 1020);
        // Broken runs of three highs never lock; 8th dwell strobe moves on.
        strobe(1020, 1'b0);
        strobe(1020, 1'b1); strobe(1020, 1'b1); strobe(1020, 1'b1);
        strobe(1020, 1'b0);
        strobe(1020, 1'b1); strobe(1020, 1'b1); strobe(1020, 1'b1);
        chk("dwell7_still_bin", dopset, 1020);
        chk("dwell7_not_locked", locked, 0);
        strobe(1020, 1'b0);
        chk("dwell8_next_bin", dopset, 1030);
        skip_bin(1030);
        skip_bin(1040);
        chk("reach_1050", dopset, 1050);

        // Tolerance: +3 and -3 do not settle, -2 does. A wrong early settle
        // would let the following highs lock one strobe too soon.
        strobe(1053, 1'b1);
        strobe(1047, 1'b1);
        strobe(1048, 1'b1);
        repeat (3) strobe(1050, 1'b1);
        chk("tol_not_locked_early", locked, 0);
        strobe(1050, 1'b1);
        chk("tol_locked_1050", locked, 1);
        chk("tol_dopset_1050", dopset, 1050);

        // Two lows then a high keep lock; three lows lose it.
        strobe(1050, 1'b0); strobe(1050, 1'b0); strobe(1050, 1'b1);
        chk("loss2_still_locked", locked, 1);
        repeat (3) strobe(1050, 1'b0);
        chk("loss3_locked", locked, 0);
        chk("loss3_doptrack", doptrack, 0);
        chk("loss3_busy", busy, 1);
        chk("loss3_dopset", dopset, 1060);

        // Abort with simultaneous start and strobe while in DWELL.
        strobe(1060, 1'b0);
        abort = 1'b1; start = 1'b1; meas_valid = 1'b1; codetrack = 1'b1; iffreq = 12'd1060;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; meas_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_doptrack", doptrack, 0);
        chk("abort_dopset_held", dopset, 1060);
        strobe(1060, 1'b1);
        chk("idle_strobe_busy", busy, 0);

        // Reset mid-LOCKED.
        pulse_start();
        strobe(1000, 1'b0);
        repeat (4) strobe(1000, 1'b1);
        chk("relock_locked", locked, 1);
        strobe(1000, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_flags", {doptrack, locked, fail}, 0);
        chk("midrst_dopset", dopset, 1000);

        // Bin timing and sweep wrap up to FAIL.
        pulse_start();
        repeat (15) strobe(0, 1'b0);
        chk("settle15_same_bin", dopset, 1000);
        strobe(0, 1'b0);
        chk("settle16_next_bin", dopset, 1010);
        repeat (9) repeat (16) strobe(0, 1'b0);
        chk("bin_1100", dopset, 1100);
        pulse_abort();
        pulse_start();
        run_sweeps();
        chk("fail_flag", fail, 1);
        chk("fail_busy", busy, 0);
        chk("fail_doptrack", doptrack, 0);
        strobe(1000, 1'b1);
        chk("fail_holds", fail, 1);

        // start from FAIL gives a fresh search.
        pulse_start();
        chk("fail_start_busy", busy, 1);
        chk("fail_start_fail", fail, 0);
        chk("fail_start_sweep", sweep, 0);
        chk("fail_start_dopset", dopset, 1000);

        // abort from FAIL returns to IDLE.
        run_sweeps();
        chk("fail2_flag", fail, 1);
        pulse_abort();
        chk("fail_abort_fail", fail, 0);
        chk("fail_abort_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
